cus19_crypto_stream_engine: RTL and testbench
=============================================

Name: cus19_crypto_stream_engine

Overview:
Sequential block-crypto engine for the Custom19 core. It accepts one command from the CU: mode, source address, destination address and length. For each byte it reads data memory, applies the Custom19 cipher, and writes the result back to memory. The cipher is the same one the IE-stage crypto unit uses: encrypt = rotate-left-3 then XOR KEY; decrypt = XOR KEY then rotate-right-3. The block sits beside the data memory as a bus initiator and frees the pipeline from byte-by-byte ENC/DEC instructions.

Parameters:
KEY, 8'hA5, cipher key; must equal the IE-stage crypto unit key.
ADDR_W, 19, data memory byte-address width.
LEN_W, 8, width of the length field and the byte counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request from CU
cmd_ready  output  1  engine idle; command accepted when cmd_valid&&cmd_ready
cmd_mode  input  1  1 = encrypt, 0 = decrypt
cmd_src  input  ADDR_W  source start address
cmd_dst  input  ADDR_W  destination start address
cmd_len  input  LEN_W  byte count (0 legal)
abort  input  1  synchronous cancel of the running command
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle pulse on normal completion
byte_count  output  LEN_W  bytes written for the current or last command
mem_req  output  1  memory request; held until mem_ack
mem_we  output  1  1 = write, 0 = read; valid with mem_req
mem_addr  output  ADDR_W  memory byte address
mem_wdata  output  8  write data
mem_rdata  input  8  read data; valid in the mem_ack cycle of a read
mem_ack  input  1  request completes in this cycle; may be asserted in the same cycle as mem_req

Behaviour:
- Reset (asynchronous, any state): state=IDLE, cmd_ready=1, busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, byte_count=0, all internal latches 0.
- State machine: IDLE, READ, XFORM, WRITE, DONE. mem_req=1 only in READ and WRITE. mem_we=1 only in WRITE.
- IDLE:
  - cmd_ready=1.
  - On accept: latch mode, src, dst, len; clear the index and byte_count.
  - len==0 goes to DONE. Otherwise goes to READ with mem_addr=src.
  - cmd_valid while not IDLE is ignored; cmd_ready=0.
- READ: hold mem_req, mem_addr=src+idx. On mem_ack, capture mem_rdata and go to XFORM. Wait states of any length are legal.
- XFORM: single cycle.
  - Encrypt: mem_wdata = {d[4:0],d[7:5]} ^ KEY.
  - Decrypt: t = d ^ KEY, then mem_wdata = {t[2:0],t[7:3]}.
  - Set mem_addr = dst+idx, then go to WRITE.
- WRITE: hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_ack. On ack:
  - byte_count++ and idx++.
  - If the new idx==len, go to DONE. Otherwise go to READ with mem_addr=src+new idx.
- DONE: done=1 for exactly one cycle, then IDLE. busy is still 1 during the DONE cycle.
- Address arithmetic is modulo 2^ADDR_W; addresses wrap silently past the top.
- Overlap: src==dst (in-place) is legal and correct, because each byte is read before it is written. Other overlaps are processed strictly in ascending index order.
- Latency with zero-wait memory (ack in the request cycle), command accepted at cycle T0:
  - First mem_req at T0+1.
  - 3 cycles per byte.
  - done at T0+3*len+1.
  - len==0: done at T0+1, no memory access.
- Abort: highest priority after reset. In any non-IDLE state, the next state is IDLE, mem_req drops the next cycle, and done is not pulsed.
  - byte_count keeps the bytes completed so far.
  - If abort and mem_ack coincide in WRITE, the write counts as performed, but byte_count is not incremented (abort wins).
  - Abort in IDLE has no effect; abort together with cmd_valid in IDLE accepts the command normally.
- Outputs are registered except cmd_ready, busy, mem_req and mem_we, which decode directly from state.

Test Plan:
- Encrypt 1 byte, zero-wait memory: mem[0x100]=0x01; cmd_mode=1, cmd_src=0x100, cmd_dst=0x200, cmd_len=1 -> writes 0xAD to 0x200; done exactly 4 cycles after accept; byte_count=1.
- Round trip over 3 bytes with 2-cycle ack delay: encrypt 0x01,0x80,0xFF to 0xAD,0xA1,0x5A; decrypt in place restores 0x01,0x80,0xFF; mem_addr and mem_wdata stay stable throughout each wait.
- len=0 -> done one cycle after accept; mem_req never asserts; byte_count=0.
- Wrap: cmd_src=0x7FFFF, cmd_len=2 -> reads 0x7FFFF then 0x00000.
- Abort in WRITE of byte 2 (len=4), no ack -> IDLE next cycle; mem_req=0; no done; byte_count=1; cmd_ready=1; a new command is then accepted.
- Async reset asserted mid-READ -> all outputs zero immediately, cmd_ready=1; cmd_valid pulses while busy are ignored.

Source files
------------

// File: rtl/cus19_crypto_stream_engine.sv
`default_nettype none
// ============================================================================
// cus19_crypto_stream_engine : memory-to-memory Custom19 cipher engine
// Rev 1.0
// ============================================================================
module cus19_crypto_stream_engine #(
  parameter logic [7:0] KEY    = 8'hA5,
  parameter int         ADDR_W = 19,
  parameter int         LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  byte_count,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_XFORM = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q;
  logic                mode_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    idx_q;
  logic [LEN_W-1:0]    count_q;
  logic [7:0]          data_q;
  logic [7:0]          wdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                done_q;
  logic [LEN_W-1:0]    idx_d;

  function automatic logic [7:0] enc_f(input logic [7:0] d);
    enc_f = {d[4:0], d[7:5]} ^ KEY;
  endfunction

  function automatic logic [7:0] dec_f(input logic [7:0] d);
    logic [7:0] t;
    t     = d ^ KEY;
    dec_f = {t[2:0], t[7:3]};
  endfunction

  assign idx_d = idx_q + LEN_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else if (abort && (state_q != S_IDLE)) begin
      // Cancel wins over any coincident ack: progress so far is kept as-is.
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            mode_q  <= cmd_mode;
            src_q   <= cmd_src;
            dst_q   <= cmd_dst;
            len_q   <= cmd_len;
            idx_q   <= '0;
            count_q <= '0;
            if (cmd_len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_READ;
              addr_q  <= cmd_src;
            end
          end
        end
        S_READ: begin
          if (mem_ack) begin
            data_q  <= mem_rdata;
            state_q <= S_XFORM;
          end
        end
        S_XFORM: begin
          wdata_q <= mode_q ? enc_f(data_q) : dec_f(data_q);
          addr_q  <= dst_q + ADDR_W'(idx_q);
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          if (mem_ack) begin
            count_q <= count_q + LEN_W'(1);
            idx_q   <= idx_d;
            if (idx_d == len_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_READ;
              addr_q  <= src_q + ADDR_W'(idx_d);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign mem_req    = (state_q == S_READ) || (state_q == S_WRITE);
  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign done       = done_q;
  assign byte_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_cus19_crypto_stream_engine.sv
`default_nettype none
// ============================================================================
// tb_cus19_crypto_stream_engine : bench for the Custom19 stream engine
// Rev 1.0
// ============================================================================
module tb_cus19_crypto_stream_engine;

  localparam int ADDR_W = 19;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_mode;
  logic [ADDR_W-1:0] cmd_src;
  logic [ADDR_W-1:0] cmd_dst;
  logic [LEN_W-1:0]  cmd_len;
  logic              abort;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  byte_count;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  always #5 clk = ~clk;

  cus19_crypto_stream_engine #(
    .KEY    (8'hA5),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_len    (cmd_len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .byte_count (byte_count),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  // Byte-addressed memory with programmable wait states and a write-ack cutoff.
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  int  ack_delay = 0;
  int  wcnt      = 0;
  bit  ack_off   = 1'b0;
  int  wr_total  = 0;
  int  wr_limit  = 1000000;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && !ack_off && (wcnt >= ack_delay) &&
                     !(mem_we && (wr_total >= wr_limit));

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [ADDR_W-1:0]   exp_rd [$];
  logic [ADDR_W+7:0]   exp_wr [$];

  typedef struct packed {
    logic              mode;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
    logic [3:0]        dly;
    logic [3:0][7:0]   din;
    logic [3:0][7:0]   expv;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mem_model();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        wcnt <= 0;
      end else if (mem_req && mem_ack) begin
        if (mem_we) begin
          mem[mem_addr] <= mem_wdata;
          wr_total      <= wr_total + 1;
        end
        wcnt <= 0;
      end else if (mem_req) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
      end
    end
  endtask

  task automatic monitor();
    logic              pr, pa, pwe, pdone;
    logic [ADDR_W-1:0] paddr;
    logic [7:0]        pwd;
    logic [ADDR_W+7:0] w;
    pr = 1'b0; pa = 1'b0; pwe = 1'b0; pdone = 1'b0; paddr = '0; pwd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pr = 1'b0;
        pdone = 1'b0;
        continue;
      end
      if (pr && !pa && mem_req) begin
        chk("wait_addr_stable", 32'(mem_addr), 32'(paddr));
        chk("wait_wdata_stable", 32'(mem_wdata), 32'(pwd));
        chk("wait_we_stable", 32'(mem_we), 32'(pwe));
      end
      if (mem_req && mem_ack) begin
        if (mem_we) begin
          if (exp_wr.size() == 0) begin
            chk("unexpected_write", 32'(exp_wr.size()), 32'd1);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(w[ADDR_W+7:8]));
            chk("wr_data", 32'(mem_wdata), 32'(w[7:0]));
          end
        end else begin
          if (exp_rd.size() == 0) begin
            chk("unexpected_read", 32'(exp_rd.size()), 32'd1);
          end else begin
            chk("rd_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
          end
        end
      end
      if (pdone) chk("done_one_cycle", 32'(done), 32'd0);
      if (done) done_cnt++;
      pr = mem_req; pa = mem_ack; pwe = mem_we; paddr = mem_addr; pwd = mem_wdata; pdone = done;
    end
  endtask

  task automatic issue(input logic mode, input logic [ADDR_W-1:0] src,
                       input logic [ADDR_W-1:0] dst, input logic [LEN_W-1:0] len,
                       input logic with_abort);
    @(negedge clk);
    chk("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = len;
    abort     = with_abort;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  // Latency counted in cycles after the accepting edge; start = first negedge index to test.
  task automatic wait_done(input int start, output int lat);
    lat = start;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (done) break;
      lat++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int                lat;
    int                dc;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] d;

    vt[0] = '{mode:1'b1, src:19'h00100, dst:19'h00200, len:8'd1, dly:4'd0,
              din:32'h0000_0001, expv:32'h0000_00AD};
    vt[1] = '{mode:1'b1, src:19'h00300, dst:19'h00300, len:8'd3, dly:4'd2,
              din:32'h00FF_8001, expv:32'h005A_A1AD};
    vt[2] = '{mode:1'b0, src:19'h00300, dst:19'h00300, len:8'd3, dly:4'd2,
              din:32'h005A_A1AD, expv:32'h00FF_8001};
    vt[3] = '{mode:1'b1, src:19'h00400, dst:19'h00500, len:8'd0, dly:4'd0,
              din:32'h0000_0000, expv:32'h0000_0000};
    vt[4] = '{mode:1'b1, src:19'h7FFFF, dst:19'h7FFFE, len:8'd2, dly:4'd1,
              din:32'h0000_3412, expv:32'h0000_0435};
    vt[5] = '{mode:1'b0, src:19'h00600, dst:19'h00700, len:8'd2, dly:4'd0,
              din:32'h0000_005A, expv:32'h0000_B4FF};

    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; abort = 1'b0;

    fork
      mem_model();
      monitor();
    join_none

    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven commands
    for (int v = 0; v < 6; v++) begin
      ack_delay = int'(vt[v].dly);
      for (int i = 0; i < int'(vt[v].len); i++) begin
        a = vt[v].src + 19'(i);
        d = vt[v].dst + 19'(i);
        mem[a] = vt[v].din[i];
        exp_rd.push_back(a);
        exp_wr.push_back({d, vt[v].expv[i]});
      end
      issue(vt[v].mode, vt[v].src, vt[v].dst, vt[v].len, 1'b0);
      wait_done(1, lat);
      chk($sformatf("v%0d_latency", v), 32'(lat),
          32'(int'(vt[v].len) * (2 * int'(vt[v].dly) + 3) + 1));
      chk($sformatf("v%0d_busy_in_done", v), 32'(busy), 32'd1);
      chk($sformatf("v%0d_byte_count", v), 32'(byte_count), 32'(vt[v].len));
      @(negedge clk);
      chk($sformatf("v%0d_idle_after", v), 32'(cmd_ready), 32'd1);
      for (int i = 0; i < int'(vt[v].len); i++) begin
        d = vt[v].dst + 19'(i);
        chk($sformatf("v%0d_mem%0d", v, i), 32'(mem[d]), 32'(vt[v].expv[i]));
      end
      chk($sformatf("v%0d_rd_drained", v), 32'(exp_rd.size()), 32'd0);
      chk($sformatf("v%0d_wr_drained", v), 32'(exp_wr.size()), 32'd0);
    end

    // Abort while the second write is stalled
    ack_delay = 0;
    wr_limit  = wr_total + 1;
    mem[19'h00800] = 8'h01; mem[19'h00801] = 8'h80;
    mem[19'h00802] = 8'hFF; mem[19'h00803] = 8'h00;
    exp_rd.push_back(19'h00800);
    exp_wr.push_back({19'h00900, 8'hAD});
    exp_rd.push_back(19'h00801);
    dc = done_cnt;
    issue(1'b1, 19'h00800, 19'h00900, 8'd4, 1'b0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (mem_req && mem_we && !mem_ack) break;
    end
    chk("abort_write_stalled", 32'(mem_req & mem_we & ~mem_ack), 32'd1);
    @(negedge clk);
    chk("abort_wdata_byte2", 32'(mem_wdata), 32'hA1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_byte_count", 32'(byte_count), 32'd1);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
    chk("abort_rd_drained", 32'(exp_rd.size()), 32'd0);
    chk("abort_wr_drained", 32'(exp_wr.size()), 32'd0);
    wr_limit = 1000000;

    // Command presented together with abort in IDLE is still accepted
    mem[19'h00A00] = 8'h80;
    exp_rd.push_back(19'h00A00);
    exp_wr.push_back({19'h00B00, 8'hA1});
    issue(1'b1, 19'h00A00, 19'h00B00, 8'd1, 1'b1);
    wait_done(1, lat);
    chk("idle_abort_latency", 32'(lat), 32'd4);
    chk("idle_abort_byte_count", 32'(byte_count), 32'd1);
    @(negedge clk);
    chk("idle_abort_mem", 32'(mem[19'h00B00]), 32'hA1);

    // Asynchronous reset in the middle of a stalled read
    ack_off = 1'b1;
    issue(1'b1, 19'h00C00, 19'h00C80, 8'd2, 1'b0);
    @(negedge clk);
    chk("rst_mid_read_req", 32'(mem_req), 32'd1);
    chk("rst_mid_read_addr", 32'(mem_addr), 32'h00C00);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk("async_rst_mem_we", 32'(mem_we), 32'd0);
    chk("async_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("async_rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("async_rst_byte_count", 32'(byte_count), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ack_off = 1'b0;
    exp_rd.delete();
    exp_wr.delete();

    // cmd_valid pulses while busy must be ignored
    ack_delay = 2;
    mem[19'h00D00] = 8'hFF; mem[19'h00D01] = 8'h01;
    exp_rd.push_back(19'h00D00);
    exp_wr.push_back({19'h00E00, 8'h5A});
    exp_rd.push_back(19'h00D01);
    exp_wr.push_back({19'h00E01, 8'hAD});
    issue(1'b1, 19'h00D00, 19'h00E00, 8'd2, 1'b0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("busy_cmd_ready_low", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b1;
      cmd_mode  = 1'b0;
      cmd_src   = 19'h00123;
      cmd_dst   = 19'h00456;
      cmd_len   = 8'd3;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(5, lat);
    chk("busy_ignore_latency", 32'(lat), 32'd15);
    chk("busy_ignore_byte_count", 32'(byte_count), 32'd2);
    @(negedge clk);
    chk("busy_ignore_mem0", 32'(mem[19'h00E00]), 32'h5A);
    chk("busy_ignore_mem1", 32'(mem[19'h00E01]), 32'hAD);
    repeat (3) @(negedge clk);
    chk("busy_ignore_stays_idle", 32'(busy), 32'd0);
    chk("busy_ignore_rd_drained", 32'(exp_rd.size()), 32'd0);
    chk("busy_ignore_wr_drained", 32'(exp_wr.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
